// File: rtl/pipe_pkg.sv
// Shared types for the register-tracking pipeline: destination record and its NOP value.
package pipe_pkg;

  localparam int unsigned RW = 5;

  // Destination information carried down the pipe with each instruction.
  typedef struct packed {
    logic [RW-1:0] rd;
    logic          regwr;
    logic          memrd;
  } dst_t;

  localparam dst_t NOP_DST = '0;

endpackage

// File: rtl/pipe_stage.sv
// Generic pipeline register: async active-low reset, synchronous clear to zero.
module pipe_stage #(
  parameter int unsigned Width = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic [Width-1:0] i_d,
  output logic [Width-1:0] o_q
);

  logic [Width-1:0] r_q;

  // Capture every edge; clear takes priority over data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/hazard_track.sv
// Destination tracking through ID/EX, EX/MEM, MEM/WB plus load-use / branch-on-load
// hazard detection, stall/bubble generation and a saturating stall counter.
module hazard_track #(
  parameter int unsigned RW = 5,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic          id_regwr,
  input  logic          id_memrd,
  input  logic          id_uses_rt,
  input  logic          id_branch,
  input  logic          flush,
  output logic [RW-1:0] idex_rs,
  output logic [RW-1:0] idex_rt,
  output logic [RW-1:0] idex_rd,
  output logic          idex_regwr,
  output logic [RW-1:0] exmem_rd,
  output logic [RW-1:0] memwb_rd,
  output logic          exmem_regwr,
  output logic          memwb_regwr,
  output logic          stall,
  output logic          bubble,
  output logic [CW-1:0] stall_cnt
);

  import pipe_pkg::*;

  // Destination records use the package register width, which must match RW.
  localparam int unsigned DstW  = $bits(dst_t);
  localparam int unsigned IdexW = 2 * RW + DstW;
  localparam int unsigned WbW   = RW + 1;

  dst_t             w_id_dst;
  dst_t             w_idex_dst;
  dst_t             w_exmem_dst;
  logic [RW-1:0]    w_idex_rs;
  logic [RW-1:0]    w_idex_rt;
  logic [IdexW-1:0] w_idex_d;
  logic [IdexW-1:0] w_idex_q;
  logic [WbW-1:0]   w_memwb_d;
  logic [WbW-1:0]   w_memwb_q;
  logic             w_lu;
  logic             w_bl;
  logic [CW-1:0]    r_stall_cnt;

  // A squashed ID instruction carries no destination.
  assign w_id_dst = flush ? NOP_DST : {id_rd, id_regwr, id_memrd};
  assign w_idex_d = {id_rs, id_rt, w_id_dst};

  pipe_stage #(
    .Width(IdexW)
  ) u_idex (
    .i_clk  (clk),
    .i_rst_n(reset),
    .i_clr  (bubble),
    .i_d    (w_idex_d),
    .o_q    (w_idex_q)
  );

  assign {w_idex_rs, w_idex_rt, w_idex_dst} = w_idex_q;

  // EX/MEM and MEM/WB never freeze; stalls only hold the front end.
  pipe_stage #(
    .Width(DstW)
  ) u_exmem (
    .i_clk  (clk),
    .i_rst_n(reset),
    .i_clr  (1'b0),
    .i_d    (w_idex_dst),
    .o_q    (w_exmem_dst)
  );

  assign w_memwb_d = {w_exmem_dst.rd, w_exmem_dst.regwr};

  pipe_stage #(
    .Width(WbW)
  ) u_memwb (
    .i_clk  (clk),
    .i_rst_n(reset),
    .i_clr  (1'b0),
    .i_d    (w_memwb_d),
    .o_q    (w_memwb_q)
  );

  // Load in EX feeding a source in ID; rt only counts when it is actually read.
  assign w_lu = w_idex_dst.memrd && (w_idex_dst.rd != '0) &&
                ((w_idex_dst.rd == id_rs) || (id_uses_rt && (w_idex_dst.rd == id_rt)));

  // Branch resolved in ID needs a load result still sitting in MEM.
  assign w_bl = id_branch && w_exmem_dst.memrd && (w_exmem_dst.rd != '0) &&
                ((w_exmem_dst.rd == id_rs) || (w_exmem_dst.rd == id_rt));

  // Flush discards the ID instruction, so its hazard no longer matters.
  assign stall  = (w_lu || w_bl) && !flush;
  assign bubble = stall || flush;

  // Count stalled cycles, sticking at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (stall && (r_stall_cnt != {CW{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CW'(1);
    end
  end

  assign idex_rs     = w_idex_rs;
  assign idex_rt     = w_idex_rt;
  assign idex_rd     = w_idex_dst.rd;
  assign idex_regwr  = w_idex_dst.regwr;
  assign exmem_rd    = w_exmem_dst.rd;
  assign exmem_regwr = w_exmem_dst.regwr;
  assign memwb_rd    = w_memwb_q[WbW-1:1];
  assign memwb_regwr = w_memwb_q[0];
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_hazard_track.sv
// Self-checking bench for hazard_track: vector table plus hand sequences, scoreboard of
// expected pipeline state checked after every edge.
module tb_hazard_track;

  localparam int unsigned RW = 5;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          reset;
  logic [RW-1:0] id_rs, id_rt, id_rd;
  logic          id_regwr, id_memrd, id_uses_rt, id_branch, flush;
  logic [RW-1:0] idex_rs, idex_rt, idex_rd, exmem_rd, memwb_rd;
  logic          idex_regwr, exmem_regwr, memwb_regwr;
  logic          stall, bubble;
  logic [CW-1:0] stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  hazard_track #(
    .RW(RW),
    .CW(CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rd      (id_rd),
    .id_regwr   (id_regwr),
    .id_memrd   (id_memrd),
    .id_uses_rt (id_uses_rt),
    .id_branch  (id_branch),
    .flush      (flush),
    .idex_rs    (idex_rs),
    .idex_rt    (idex_rt),
    .idex_rd    (idex_rd),
    .idex_regwr (idex_regwr),
    .exmem_rd   (exmem_rd),
    .memwb_rd   (memwb_rd),
    .exmem_regwr(exmem_regwr),
    .memwb_regwr(memwb_regwr),
    .stall      (stall),
    .bubble     (bubble),
    .stall_cnt  (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1);
  end

  typedef struct {
    logic       rst_before;
    logic [4:0] rs, rt, rd;
    logic       regwr, memrd, uses_rt, branch, fl;
    logic       exp_stall, exp_bubble;
  } vec_t;

  typedef struct {
    logic [4:0] rs, rt, rd;
    logic       regwr;
    logic [4:0] xrd;
    logic       xregwr;
    logic [4:0] wrd;
    logic       wregwr;
    logic [3:0] cnt;
  } exp_t;

  exp_t sb[$];

  // Reference model of the pipeline state
  logic [4:0] m_rs, m_rt, m_rd, m_xrd, m_wrd;
  logic       m_regwr, m_memrd, m_xregwr, m_xmemrd, m_wregwr;
  logic [3:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit rst, input int rs, input int rt, input int rd,
                              input bit rw, input bit mr, input bit ut, input bit br,
                              input bit fl, input bit es, input bit eb);
    vec_t v;
    v.rst_before = rst;
    v.rs = 5'(rs); v.rt = 5'(rt); v.rd = 5'(rd);
    v.regwr = rw; v.memrd = mr; v.uses_rt = ut; v.branch = br; v.fl = fl;
    v.exp_stall = es; v.exp_bubble = eb;
    return v;
  endfunction

  task automatic set_inputs(input vec_t v);
    id_rs = v.rs; id_rt = v.rt; id_rd = v.rd;
    id_regwr = v.regwr; id_memrd = v.memrd; id_uses_rt = v.uses_rt;
    id_branch = v.branch; flush = v.fl;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_idex_rs"}, idex_rs, 0);
    chk({tag, "_idex_rt"}, idex_rt, 0);
    chk({tag, "_idex_rd"}, idex_rd, 0);
    chk({tag, "_idex_regwr"}, idex_regwr, 0);
    chk({tag, "_exmem_rd"}, exmem_rd, 0);
    chk({tag, "_exmem_regwr"}, exmem_regwr, 0);
    chk({tag, "_memwb_rd"}, memwb_rd, 0);
    chk({tag, "_memwb_regwr"}, memwb_regwr, 0);
    chk({tag, "_stall_cnt"}, stall_cnt, 0);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_bubble"}, bubble, 0);
  endtask

  // Assert reset between edges, check outputs clear at once, release before next edge.
  task automatic do_reset();
    @(negedge clk);
    set_inputs(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2 reset = 1'b0;
    #1 check_zero("rst");
    {m_rs, m_rt, m_rd, m_regwr, m_memrd} = '0;
    {m_xrd, m_xregwr, m_xmemrd, m_wrd, m_wregwr} = '0;
    m_cnt = '0;
    sb.delete();
    #1 reset = 1'b1;
  endtask

  task automatic check_sb();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_empty: got no entry, want one entry");
    end else begin
      e = sb.pop_front();
      chk("idex_rs", idex_rs, e.rs);
      chk("idex_rt", idex_rt, e.rt);
      chk("idex_rd", idex_rd, e.rd);
      chk("idex_regwr", idex_regwr, e.regwr);
      chk("exmem_rd", exmem_rd, e.xrd);
      chk("exmem_regwr", exmem_regwr, e.xregwr);
      chk("memwb_rd", memwb_rd, e.wrd);
      chk("memwb_regwr", memwb_regwr, e.wregwr);
      chk("stall_cnt", stall_cnt, e.cnt);
    end
  endtask

  // One cycle: drive at negedge, check combinational outputs, advance model, check after edge.
  task automatic drive(input vec_t v, input bit hand);
    logic lu, bl, st, bb;
    exp_t e;
    @(negedge clk);
    set_inputs(v);
    lu = m_memrd && (m_rd != 0) && ((m_rd == v.rs) || (v.uses_rt && (m_rd == v.rt)));
    bl = v.branch && m_xmemrd && (m_xrd != 0) && ((m_xrd == v.rs) || (m_xrd == v.rt));
    st = (lu || bl) && !v.fl;
    bb = st || v.fl;
    #1;
    chk("stall_model", stall, st);
    chk("bubble_model", bubble, bb);
    if (hand) begin
      chk("stall_vec", stall, v.exp_stall);
      chk("bubble_vec", bubble, v.exp_bubble);
    end
    m_wrd = m_xrd; m_wregwr = m_xregwr;
    m_xrd = m_rd; m_xregwr = m_regwr; m_xmemrd = m_memrd;
    if (bb) begin
      {m_rs, m_rt, m_rd, m_regwr, m_memrd} = '0;
    end else begin
      m_rs = v.rs; m_rt = v.rt; m_rd = v.rd; m_regwr = v.regwr; m_memrd = v.memrd;
    end
    if (st && (m_cnt != 4'hf)) m_cnt = m_cnt + 4'd1;
    e.rs = m_rs; e.rt = m_rt; e.rd = m_rd; e.regwr = m_regwr;
    e.xrd = m_xrd; e.xregwr = m_xregwr; e.wrd = m_wrd; e.wregwr = m_wregwr;
    e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1 check_sb();
  endtask

  vec_t tbl[19];
  vec_t nop;

  initial begin
    reset = 1'b0;
    set_inputs(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //          rst rs rt rd rw mr ut br fl  st bb
    tbl[0]  = mk(1, 9, 8, 8, 1, 1, 0, 0, 0, 0, 0);  // lw $8
    tbl[1]  = mk(0, 8, 10, 9, 1, 0, 1, 0, 0, 1, 1); // add $9,$8,$10 -> load-use
    tbl[2]  = mk(0, 8, 10, 9, 1, 0, 1, 0, 0, 0, 0); // add retried
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1, 9, 8, 8, 1, 1, 0, 0, 0, 0, 0);  // lw $8
    tbl[5]  = mk(0, 8, 0, 0, 0, 0, 1, 1, 0, 1, 1);  // beq $8,$0: lu
    tbl[6]  = mk(0, 8, 0, 0, 0, 0, 1, 1, 0, 1, 1);  // beq: bl
    tbl[7]  = mk(0, 8, 0, 0, 0, 0, 1, 1, 0, 0, 0);  // beq proceeds
    tbl[8]  = mk(1, 9, 0, 0, 1, 1, 0, 0, 0, 0, 0);  // lw $0
    tbl[9]  = mk(0, 0, 0, 9, 1, 0, 1, 0, 0, 0, 0);  // add $9,$0,$0
    tbl[10] = mk(0, 9, 8, 8, 1, 1, 0, 0, 0, 0, 0);  // lw $8
    tbl[11] = mk(0, 8, 8, 9, 1, 0, 0, 0, 0, 1, 1);  // addi $9,$8: rs hazard
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[13] = mk(0, 9, 8, 8, 1, 1, 0, 0, 0, 0, 0);  // lw $8
    tbl[14] = mk(0, 3, 8, 9, 1, 0, 0, 0, 0, 0, 0);  // rt=8 not read: no stall
    tbl[15] = mk(1, 9, 8, 8, 1, 1, 0, 0, 0, 0, 0);  // lw $8
    tbl[16] = mk(0, 8, 10, 9, 1, 0, 1, 0, 1, 0, 1); // hazard + flush
    tbl[17] = mk(0, 8, 10, 9, 1, 0, 1, 0, 0, 0, 0);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);  // flush on empty pipe

    for (int i = 0; i < 19; i++) begin
      if (tbl[i].rst_before) do_reset();
      drive(tbl[i], 1'b1);
      if (i == 1) begin
        chk("lu_bubble_idex_rd", idex_rd, 0);
        chk("lu_bubble_idex_regwr", idex_regwr, 0);
      end
      if (i == 2) chk("lu_add_enters_idex", idex_rd, 9);
      if (i == 3) chk("lu_stall_cnt", stall_cnt, 1);
      if (i == 5) chk("bl_exmem_rd", exmem_rd, 8);
      if (i == 7) chk("bl_stall_cnt", stall_cnt, 2);
      if (i == 18) chk("flush_stall_cnt", stall_cnt, 0);
    end

    // Latency through the three stages, then reset with the pipe loaded
    do_reset();
    drive(mk(0, 1, 2, 5, 1, 0, 0, 0, 0, 0, 0), 1'b0);
    chk("lat_idex_rd", idex_rd, 5);
    drive(nop, 1'b0);
    chk("lat_exmem_rd", exmem_rd, 5);
    drive(nop, 1'b0);
    chk("lat_memwb_rd", memwb_rd, 5);
    chk("lat_memwb_regwr", memwb_regwr, 1);
    do_reset();

    // Reset while a load-use stall is showing
    drive(mk(0, 9, 8, 8, 1, 1, 0, 0, 0, 0, 0), 1'b0);
    @(negedge clk);
    set_inputs(mk(0, 8, 10, 9, 1, 0, 1, 0, 0, 0, 0));
    #1 chk("midstall_stall_before", stall, 1);
    reset = 1'b0;
    #1;
    chk("midstall_stall_after", stall, 0);
    chk("midstall_bubble_after", bubble, 0);
    chk("midstall_idex_rd", idex_rd, 0);
    do_reset();

    // Repeated load-use (lw $8,0($8) back to back) stalls every other cycle
    for (int k = 0; k < 40; k++) drive(mk(0, 8, 8, 8, 1, 1, 0, 0, 0, 0, 0), 1'b0);
    chk("sat_stall_cnt", stall_cnt, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_track.md
# hazard_track

Register-tracking pipeline and hazard controller for the five-stage MIPS core. It carries each instruction's destination register, write-enable and load flag from ID through the ID/EX, EX/MEM and MEM/WB stages, and supplies those fields to the forwarding unit. It also detects the load-use and branch-on-load hazards that forwarding cannot cover. On such a hazard it stalls PC and IF/ID and injects bubbles into ID/EX.

## Interface
- `RW`, default 5: register index width.
- `CW`, default 16: stall-cycle counter width.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `id_rs`, `id_rt`  in  RW  source fields of the instruction in ID.
- `id_rd`  in  RW  destination after the RegDst mux (rt, rd or 31).
- `id_regwr`  in  1  instruction in ID writes the register file.
- `id_memrd`  in  1  instruction in ID is a load.
- `id_uses_rt`  in  1  rt is read as a source (R-type, beq/bne, sw).
- `id_branch`  in  1  beq/bne/jr in ID; needs operands in ID.
- `flush`  in  1  squash the instruction currently in ID.
- `idex_rs`, `idex_rt`, `idex_rd`  out  RW  ID/EX fields.
- `idex_regwr`  out  1  ID/EX write-enable.
- `exmem_rd`, `memwb_rd`  out  RW  EX/MEM and MEM/WB destination fields.
- `exmem_regwr`, `memwb_regwr`  out  1  EX/MEM and MEM/WB write-enables.
- `stall`  out  1  combinational; hold PC and IF/ID this cycle.
- `bubble`  out  1  combinational; ID/EX loads a NOP this edge.
- `stall_cnt`  out  CW  saturating count of cycles with `stall` high.

## Operation
- **Load-use hazard.** `lu` = `idex_memrd` & `idex_rd`≠0 & (`idex_rd`==`id_rs` | (`id_uses_rt` & `idex_rd`==`id_rt`)).
- **Branch-on-load hazard.** `bl` = `id_branch` & `exmem_memrd` & `exmem_rd`≠0 & (`exmem_rd`==`id_rs` | `exmem_rd`==`id_rt`).
  - `exmem_memrd` is internal state; it is not a port.
- **Stall output.** `stall` = (`lu` | `bl`) & ~`flush`.
- **Bubble output.** `bubble` = `stall` | `flush`.
- **Branch on an ALU result in EX** needs no stall; the forwarding unit's ID/EX path covers it.
- **A branch depending on a load in EX** stalls for 2 cycles: cycle 1 via `lu` with `id_branch` set (rt counts as used), cycle 2 via `bl`.
- **ID/EX update each edge:**
  - If `bubble`: rs, rt and rd are cleared to 0; regwr and memrd are cleared.
  - Otherwise: ID/EX loads the `id_*` inputs.
- **EX/MEM and MEM/WB** advance unconditionally every edge. Stalls never freeze them.
- **Rd = 0.** A destination of 0 is carried unchanged. The consumer ignores it; this block never masks regwr.
- **`stall_cnt`** increments on each edge where `stall`=1 and saturates at all-ones.
- **`flush` together with a hazard:** `flush` wins. `stall`=0, a bubble is inserted, and the counter does not increment.

## Timing
- **Reset** (`reset`=0, asynchronous): every register clears to 0.
  - Affected: all `idex_*`, `exmem_*`, `memwb_*`, the internal memrd flags and `stall_cnt`.
  - `stall` and `bubble` evaluate to 0 while the pipeline is empty, unless `flush`=1; `bubble` follows `flush`.
- **Release:** the first capturing edge is the first rising edge with `reset`=1.
- **Latency:** an ID-stage field appears on the `idex_*` outputs 1 edge later, `exmem_*` after 2 and `memwb_*` after 3.
- **`stall` and `bubble`** are purely combinational from the current inputs and state. They are valid in the same cycle.
- **Reset mid-stall:** pending hazards are lost, and `stall` drops as soon as `reset` asserts.

## Structure
- **Shared package `pipe_pkg`:**
  - `RW`.
  - Typedef `dst_t` = {rd[RW], regwr, memrd}.
  - Constant `NOP_DST` = all zeros.
- **Sub-module `pipe_stage`:** parameterised register with async active-low reset, synchronous clear and data-width parameter.
  - Instantiated once for ID/EX (clear = `bubble`).
  - Instantiated twice for EX/MEM and MEM/WB (clear tied 0).
- **Top level** holds the hazard comparators and the stall counter.

## Test plan
- **Load-use:** `lw $8` in ID, then `add $9,$8,$10` in ID the next cycle → `stall`=1 and `bubble`=1 for exactly 1 cycle. The next edge gives `idex_rd`=0 and `idex_regwr`=0. The add enters ID/EX one edge later. `stall_cnt`=1.
- **Branch on load:** `lw $8` followed by `beq $8,$0` → `stall` high 2 consecutive cycles; `stall_cnt`=2. `exmem_rd`=8 during the second stall cycle.
- **No false stall:** `lw $0`, then `add $9,$0,$0` → `stall`=0. `lw $8`, then `addi $9,$8` with `id_uses_rt`=0 and rt=8 → `stall`=1, because the hazard comes from rs=8.
- **Flush priority:** a load-use hazard with `flush`=1 in the same cycle → `stall`=0, `bubble`=1, `stall_cnt` unchanged.
- **Latency and reset:** issue rd=5/regwr=1 → `idex_rd`=5 at edge 1, `exmem_rd`=5 at edge 2, `memwb_rd`=5 at edge 3. Assert `reset` between edges → all outputs read 0 immediately.
- **Saturation:** with `CW`=4, hold a hazard for 20 cycles → `stall_cnt`=15.
